// File: rtl/mem_router_pkg.sv
// ============================================================================
// mem_router_pkg
// Shared FSM encoding, funct3 width codes and load-lane extraction.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  funct3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (funct3)
            F3_B:    lane_extend = {{24{sh[7]}}, sh[7:0]};
            F3_H:    lane_extend = {{16{sh[15]}}, sh[15:0]};
            F3_W:    lane_extend = sh;
            F3_BU:   lane_extend = {24'd0, sh[7:0]};
            F3_HU:   lane_extend = {16'd0, sh[15:0]};
            default: lane_extend = 32'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_router_decode.sv
// ============================================================================
// mem_router_decode
// Combinational window match: one-hot hit (lowest index wins), miss, offset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_router_decode #(
    parameter int                       N_CH         = 4,
    parameter int                       ADDR_W       = 32,
    parameter logic [N_CH*ADDR_W-1:0]   CH_BASE      = '0,
    parameter logic [N_CH*5-1:0]        CH_SIZE_LOG2 = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [N_CH-1:0]   o_hit,
    output logic              o_miss,
    output logic [ADDR_W-1:0] o_offset
);

    logic [N_CH-1:0]   w_match;
    logic [ADDR_W-1:0] w_mask [N_CH];

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_win
            localparam logic [ADDR_W-1:0] c_BASE = CH_BASE[g*ADDR_W +: ADDR_W];
            localparam logic [4:0]        c_SIZE = CH_SIZE_LOG2[g*5 +: 5];
            assign w_match[g] = ((i_addr ^ c_BASE) >> c_SIZE) == '0;
            assign w_mask[g]  = ~({ADDR_W{1'b1}} << c_SIZE);
        end
    endgenerate

    // Walk downwards so the lowest matching index is the last to overwrite.
    always_comb begin
        o_hit    = '0;
        o_offset = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit    = '0;
                o_hit[i] = 1'b1;
                o_offset = i_addr & w_mask[i];
            end
        end
    end

    assign o_miss = ~|w_match;

endmodule

`default_nettype wire

// File: rtl/mem_router.sv
// ============================================================================
// mem_router
// Routes single CPU load/store requests to N_CH address-windowed peripherals.
// Optional wait timeout: define MEM_ROUTER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_router
    import mem_router_pkg::*;
#(
    parameter int                       N_CH         = 4,
    parameter int                       ADDR_W       = 32,
    parameter logic [N_CH*ADDR_W-1:0]   CH_BASE      = {32'h0080_0040, 32'h0080_0030,
                                                        32'h0080_0020, 32'h0000_0000},
    parameter logic [N_CH*5-1:0]        CH_SIZE_LOG2 = {5'd4, 5'd4, 5'd4, 5'd23},
    parameter int                       TIMEOUT_CYC  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [31:0]          req_wdata,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_fault,
    output logic [N_CH-1:0]      ch_req,
    output logic [ADDR_W-1:0]    ch_addr,
    output logic [31:0]          ch_wdata,
    output logic [3:0]           ch_be,
    output logic                 ch_write,
    input  logic [N_CH-1:0]      ch_ack,
    input  logic [N_CH*32-1:0]   ch_rdata,
    input  logic [N_CH-1:0]      ch_err
);

    state_t              r_state;
    state_t              w_next;
    logic [N_CH-1:0]     r_sel;
    logic [ADDR_W-1:0]   r_ch_addr;
    logic [31:0]         r_ch_wdata;
    logic [3:0]          r_ch_be;
    logic                r_ch_write;
    logic [2:0]          r_funct3;
    logic [1:0]          r_off;
    logic [31:0]         r_rdata;
    logic                r_fault;

    logic [N_CH-1:0]     w_hit;
    logic                w_miss;
    logic [ADDR_W-1:0]   w_offset;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_reject;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic                w_ack_sel;
    logic                w_err_sel;
    logic [31:0]         w_word;
    logic                w_timeout;
    logic                w_accept;

    mem_router_decode #(
        .N_CH         (N_CH),
        .ADDR_W       (ADDR_W),
        .CH_BASE      (CH_BASE),
        .CH_SIZE_LOG2 (CH_SIZE_LOG2)
    ) u_decode (
        .i_addr   (req_addr),
        .o_hit    (w_hit),
        .o_miss   (w_miss),
        .o_offset (w_offset)
    );

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
    assign w_misalign = ((req_funct3[1:0] == SZ_H) && req_addr[0]) ||
                        ((req_funct3[1:0] == SZ_W) && (req_addr[1:0] != 2'b00));
    assign w_reject   = w_miss || w_misalign || w_illegal;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3[1:0])
            SZ_B: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Acks, errors and read data from unselected channels are masked off.
    assign w_ack_sel = |(ch_ack & r_sel);
    assign w_err_sel = |(ch_ack & ch_err & r_sel);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_sel[i]) w_word = w_word | ch_rdata[i*32 +: 32];
        end
    end

`ifdef MEM_ROUTER_TIMEOUT_EN
    localparam int c_TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [c_TIMER_W-1:0] r_timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state != ST_WAIT) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) &&
                       (r_timer == c_TIMER_W'(TIMEOUT_CYC - 1));
`else
    // TIMEOUT_CYC only shapes hardware in the timeout build.
    if (TIMEOUT_CYC < 1) begin : g_no_timeout
    end
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = w_reject ? ST_RESP : ST_WAIT;
            ST_WAIT: if (w_ack_sel || w_timeout) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel      <= '0;
            r_ch_addr  <= '0;
            r_ch_wdata <= '0;
            r_ch_be    <= '0;
            r_ch_write <= 1'b0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_rdata    <= '0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel      <= w_reject ? '0 : w_hit;
                        r_ch_addr  <= w_offset;
                        r_ch_wdata <= w_wdata;
                        r_ch_be    <= w_reject ? 4'b0000 : w_be;
                        r_ch_write <= req_write && !w_reject;
                        r_funct3   <= req_funct3;
                        r_off      <= req_addr[1:0];
                        r_rdata    <= '0;
                        r_fault    <= w_reject;
                    end
                end
                ST_WAIT: begin
                    if (w_ack_sel) begin
                        r_fault <= w_err_sel;
                        r_rdata <= (w_err_sel || r_ch_write) ? 32'd0 :
                                   lane_extend(w_word, r_off, r_funct3);
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: begin
                    r_fault <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_fault = r_fault;
    assign ch_req    = (r_state == ST_WAIT) ? r_sel : '0;
    assign ch_addr   = r_ch_addr;
    assign ch_wdata  = r_ch_wdata;
    assign ch_be     = r_ch_be;
    assign ch_write  = r_ch_write;

endmodule

`default_nettype wire

// File: doc/mem_router.md
MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of peripheral channels, 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter CH_BASE, default {32'h0080_0040, 32'h0080_0030, 32'h0080_0020, 32'h0000_0000}: packed N_CH x ADDR_W base addresses, channel 0 in the LSBs.
REQ-004 SHALL have parameter CH_SIZE_LOG2, default {5'd4, 5'd4, 5'd4, 5'd23}: packed N_CH x 5 window sizes as log2 bytes; every base is size-aligned.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: channel wait limit in cycles.
REQ-006 Ports SHALL be:
  clk  in  1  clock; all state changes on its rising edge
  reset  in  1  asynchronous, active-high reset
  req_valid  in  1  CPU request strobe
  req_ready  out  1  router accepts request
  req_addr  in  ADDR_W  byte address
  req_wdata  in  32  store data, right-aligned
  req_write  in  1  1 = store
  req_funct3  in  3  RISC-V load/store width code
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  32  extended load data
  rsp_fault  out  1  access fault, qualified by rsp_valid
  ch_req  out  N_CH  per-channel request, one-hot or zero
  ch_addr  out  ADDR_W  offset within the selected window
  ch_wdata  out  32  store data shifted to its byte lane
  ch_be  out  4  byte enables
  ch_write  out  1  store flag
  ch_ack  in  N_CH  per-channel completion
  ch_rdata  in  N_CH*32  per-channel little-endian read word
  ch_err  in  N_CH  per-channel error, qualified by ch_ack

Function
REQ-007 SHALL implement states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 Handshake: a request SHALL be accepted on an edge with req_valid=1 in IDLE, latching addr, wdata, write and funct3.
REQ-009 Decode SHALL hit channel i when (req_addr ^ base_i) >> size_i == 0; on overlapping windows the lowest index SHALL win.
REQ-010 Misalignment SHALL be: half access with addr[0]=1, or word access with addr[1:0]!=0; funct3 values 011, 110 and 111 SHALL be illegal.
REQ-011 A miss, misalignment or illegal funct3 SHALL go IDLE->RESP with rsp_fault=1 and no ch_req, so rsp_valid is high the cycle after acceptance.
REQ-012 A legal hit SHALL go IDLE->WAIT; ch_req[i] SHALL stay high through WAIT until ch_ack[i] is sampled, with ch_addr, ch_be, ch_wdata and ch_write held stable.
REQ-013 ch_be SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half) or 1111 (word); ch_wdata SHALL be req_wdata replicated into the addressed lanes.
REQ-014 ch_ack[i] sampled in WAIT SHALL move to RESP with rsp_fault=ch_err[i]; acks on unselected channels SHALL be ignored.
REQ-015 On loads, rsp_rdata SHALL be the addressed lane sign-extended (000, 001) or zero-extended (100, 101), or the whole word (010); stores and faults SHALL return 0.
REQ-016 RESP SHALL last exactly one cycle, then return to IDLE; minimum hit latency SHALL be 2 cycles from acceptance to rsp_valid.

Reset
REQ-017 Reset SHALL force IDLE, with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, ch_req=0, ch_be=0, ch_write=0 and the timeout counter at 0.
REQ-018 Reset during WAIT SHALL drop ch_req asynchronously and produce no response.

Configuration
REQ-019 With MEM_ROUTER_TIMEOUT_EN defined, a counter SHALL count cycles in WAIT; when it reaches TIMEOUT_CYC-1 without an ack, ch_req SHALL drop and the router SHALL enter RESP with rsp_fault=1. An ack in the same cycle SHALL take priority.
REQ-020 Without MEM_ROUTER_TIMEOUT_EN, the counter SHALL not exist and WAIT SHALL last indefinitely.

Structure
REQ-021 A shared package SHALL hold the state enum, the funct3 width constants and a lane-extract/extend function.
REQ-022 One sub-module, mem_router_decode, SHALL perform the combinational window match and produce a one-hot hit vector and a miss flag.

Verification
REQ-023 LW at 0x0000_0010, ch0 acks after 3 cycles with rdata 0x8899_AABB -> rsp_valid 5 cycles after acceptance, rdata 0x8899_AABB, fault 0.
REQ-024 LB at 0x0080_0023, ch1 rdata 0x80xx_xxxx -> ch_be=1000, rsp_rdata 0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
REQ-025 SH of 0x1234 at 0x0080_0032 -> ch_req=0100, ch_be=1100, ch_wdata[31:16]=0x1234, rsp rdata 0.
REQ-026 LW at 0x0080_0002 -> rsp_fault=1 one cycle after acceptance, ch_req never asserted; a load at 0x0100_0000 (miss) -> same response.
REQ-027 With MEM_ROUTER_TIMEOUT_EN and TIMEOUT_CYC=8, ch3 never acks -> ch_req drops after 8 WAIT cycles, rsp_fault=1; ack in cycle 8 -> fault 0.
REQ-028 Reset asserted during WAIT -> ch_req=0 immediately, no rsp_valid, and the next request after release is accepted.
